// File: rtl/rom_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_arb_pkg                                                  |
// | Description : Shared types and helpers for the ROM read-port arbiter.      |
// |               Controller state encoding and the requester-ID width helper. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package rom_arb_pkg;

  // Controller states: accept a request, drive the ROM, present the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rom_arb_state_t;

  // Width of a requester index. This is never below 1, so that an ID bus
  // always exists even in degenerate configurations.
  function automatic int rom_arb_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Purely combinational round-robin picker. Scans requests     |
// |               starting one past the previous winner and returns the first  |
// |               one found as a one-hot grant plus its binary index.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_grant_any
);

  // Walk last_grant+1 .. last_grant+NREQ (mod NREQ). The first active request wins.
  always_comb begin
    int w_idx;
    w_idx       = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_last_grant) + k) % NREQ;
      if (!o_grant_any && i_req[w_idx]) begin
        o_grant_any    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = IDW'(w_idx);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_read_arbiter                                             |
// | Description : Shares one combinational ROM read port among NREQ clients.  |
// |               Round-robin accept, one transaction in flight, registered    |
// |               response tagged with the requester index.                    |
// |               Optional: define ROM_ARB_PARITY_EN to add the rsp_par output |
// |               (even parity of rsp_data).                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int   AWIDTH = 3,
  parameter int   DWIDTH = 8,
  parameter int   NREQ   = 4,
  localparam int  IDW    = rom_arb_idw(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [AWIDTH-1:0]      rom_addr,
  input  logic [DWIDTH-1:0]      rom_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DWIDTH-1:0]      rsp_data
`ifdef ROM_ARB_PARITY_EN
  ,
  output logic                   rsp_par
`endif
);

  localparam logic [IDW-1:0] c_LAST_RESET = IDW'(NREQ - 1);

  rom_arb_state_t        r_state;
  rom_arb_state_t        w_state_nxt;

  logic [AWIDTH-1:0]     r_addr_q;
  logic [IDW-1:0]        r_id_q;
  logic [IDW-1:0]        r_last_grant;
  logic                  r_rsp_valid;
  logic [IDW-1:0]        r_rsp_id;
  logic [DWIDTH-1:0]     r_rsp_data;

  logic [NREQ-1:0]       w_grant;
  logic [IDW-1:0]        w_grant_idx;
  logic                  w_grant_any;
  logic [AWIDTH-1:0]     w_addr_arr [NREQ];
  logic [AWIDTH-1:0]     w_win_addr;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_release;

  // Split the packed address bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr_unpack
    assign w_addr_arr[gi] = req_addr[gi*AWIDTH +: AWIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_any  (w_grant_any)
  );

  assign w_win_addr = w_addr_arr[w_grant_idx];

  // Grants are offered only while idle and out of reset, so a request is never
  // acknowledged that the controller will not latch.
  assign req_ready = (r_state == IDLE && rst_n) ? w_grant : '0;

  // The ROM address comes straight from a register, so the ROM input stays
  // stable in every state.
  assign rom_addr  = r_addr_q;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_any) begin
          w_accept    = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request-side capture: the address is sampled only at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_q     <= '0;
      r_id_q       <= '0;
      r_last_grant <= c_LAST_RESET;
    end else if (w_accept) begin
      r_addr_q     <= w_win_addr;
      r_id_q       <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end
  end

  // Response registers: load from the ROM in READ and hold until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id_q;
      r_rsp_data  <= rom_dout;
    end else if (w_release) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ROM_ARB_PARITY_EN
  logic r_rsp_par;

  assign rsp_par = r_rsp_par;

  // Even parity travels with the data word and is loaded on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_par <= 1'b0;
    end else if (w_capture) begin
      r_rsp_par <= ^rom_dout;
    end
  end
`endif

endmodule : rom_read_arbiter
`default_nettype wire
